// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM state encoding and a
// width helper that never returns zero.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;

  function automatic int clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: tick is high on every CLK_DIV-th cycle after
// the last clear, so the first tick lands exactly CLK_DIV cycles after clr drops.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clr,
  output logic tick
);

  localparam int CW = clog2_min1(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, all CPOL/CPHA modes, one-hot active-low chip selects, valid/ready intake.
// Define SPI_MASTER_RX_EN to capture MISO into rx_data_out; otherwise the block is transmit-only.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 1,
  parameter int CLK_DIV    = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic [clog2_min1(NUM_CS)-1:0]   cs_idx_in,
  input  logic                            valid_in,
  output logic                            ready_out,
  output logic                            busy_out,
  output logic                            data_clk_out,
  output logic                            data_out,
  input  logic                            miso_in,
  output logic [NUM_CS-1:0]               sel_out,
  output logic [DATA_WIDTH-1:0]           rx_data_out,
  output logic                            rx_valid_out
);

  if (CLK_DIV < 1 || DATA_WIDTH < 2 || CS_SETUP < 1 || CS_HOLD < 1) begin : g_bad_param
    $error("spi_master: illegal parameter set");
  end

  localparam int   IW      = clog2_min1(NUM_CS);
  localparam int   NBITS2  = 2 * DATA_WIDTH;
  localparam int   PH_MAX  = (NBITS2 > CS_SETUP) ?
                             ((NBITS2 > CS_HOLD) ? NBITS2 : CS_HOLD) :
                             ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int   PW      = $clog2(PH_MAX + 1);
  localparam logic IDLE_CK = 1'(CPOL);

  spi_state_t            state;
  logic [PW-1:0]         ph_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [NUM_CS-1:0]     sel_dec;
  logic                  tick;
  logic                  lead;
  logic                  shift_last;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr      (state == IDLE),
    .tick     (tick)
  );

  // An out-of-range index matches no select line, so the word is clocked out with CS idle.
  always_comb begin
    sel_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_idx_in == IW'(i)) sel_dec[i] = 1'b0;
    end
  end

  assign lead       = ~ph_cnt[0];
  assign shift_last = (ph_cnt == PW'(NBITS2 - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      ready_out    <= 1'b1;
      busy_out     <= 1'b0;
      sel_out      <= '1;
      data_clk_out <= IDLE_CK;
      data_out     <= 1'b0;
      ph_cnt       <= '0;
      tx_sr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            state     <= SETUP;
            ready_out <= 1'b0;
            busy_out  <= 1'b1;
            sel_out   <= sel_dec;
            tx_sr     <= data_in;
            ph_cnt    <= '0;
            if (CPHA == 0) data_out <= data_in[DATA_WIDTH-1];
          end
        end
        SETUP: begin
          if (tick) begin
            if (ph_cnt == PW'(CS_SETUP - 1)) begin
              state  <= SHIFT;
              ph_cnt <= '0;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            data_clk_out <= ~data_clk_out;
            // CPHA=1 launches each bit on the leading edge; CPHA=0 already has the
            // MSB on the wire and launches the rest on trailing edges.
            if (lead) begin
              if (CPHA != 0) begin
                data_out <= tx_sr[DATA_WIDTH-1];
                tx_sr    <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
              end
            end else if (CPHA == 0 && !shift_last) begin
              data_out <= tx_sr[DATA_WIDTH-2];
              tx_sr    <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            end
            if (shift_last) begin
              state  <= HOLD;
              ph_cnt <= '0;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (ph_cnt == PW'(CS_HOLD - 1)) begin
              state     <= IDLE;
              ready_out <= 1'b1;
              busy_out  <= 1'b0;
              sel_out   <= '1;
              ph_cnt    <= '0;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  sample_en;
  logic                  done;

  assign sample_en = (state == SHIFT) && tick && (lead == (CPHA == 0));
  assign done      = (state == HOLD) && tick && (ph_cnt == PW'(CS_HOLD - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_sr        <= '0;
      rx_data_out  <= '0;
      rx_valid_out <= 1'b0;
    end else begin
      rx_valid_out <= done;
      if (sample_en) rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso_in};
      if (done) rx_data_out <= rx_sr;
    end
  end
`else
  logic unused_miso;

  assign unused_miso  = miso_in;
  assign rx_data_out  = '0;
  assign rx_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: four CPOL/CPHA instances in MISO loopback plus a
// three-select instance for out-of-range indices. Expectations follow SPI_MASTER_RX_EN.
module tb_spi_master;

`ifdef SPI_MASTER_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] cs_idx = 2'd0;
  logic       valid = 1'b0;
  logic       valid_x = 1'b0;

  wire [3:0]  ready_v, busy_v, sclk_v, mosi_v, rxv_v;
  wire [15:0] sel_flat;
  wire [31:0] rx_flat;
  wire        ready_x, busy_x, sclk_x, mosi_x, rxv_x;
  wire [2:0]  sel_x;
  wire [7:0]  rx_x;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_master #(
      .DATA_WIDTH(8), .NUM_CS(4), .CLK_DIV(4), .CPOL(g / 2), .CPHA(g % 2),
      .CS_SETUP(1), .CS_HOLD(1)
    ) u_dut (
      .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .cs_idx_in(cs_idx),
      .valid_in(valid), .ready_out(ready_v[g]), .busy_out(busy_v[g]),
      .data_clk_out(sclk_v[g]), .data_out(mosi_v[g]), .miso_in(mosi_v[g]),
      .sel_out(sel_flat[4*g +: 4]), .rx_data_out(rx_flat[8*g +: 8]),
      .rx_valid_out(rxv_v[g])
    );
  end

  spi_master #(.NUM_CS(3)) u_dut_x (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .cs_idx_in(cs_idx),
    .valid_in(valid_x), .ready_out(ready_x), .busy_out(busy_x),
    .data_clk_out(sclk_x), .data_out(mosi_x), .miso_in(mosi_x),
    .sel_out(sel_x), .rx_data_out(rx_x), .rx_valid_out(rxv_x)
  );

  // Monitor: mode-0 MOSI on rising SCLK, and rx_valid pulse counts.
  int         rise_cnt = 0;
  int         rxv_cnt [4] = '{0, 0, 0, 0};
  int         rxv_x_cnt = 0;
  logic [7:0] mosi_sh = 8'h00;
  logic       sclk_q = 1'b0;

  always @(negedge clk) begin
    sclk_q <= sclk_v[0];
    if (sclk_v[0] && !sclk_q) begin
      rise_cnt <= rise_cnt + 1;
      mosi_sh  <= {mosi_sh[6:0], mosi_v[0]};
    end
    for (int g = 0; g < 4; g++) begin
      if (rxv_v[g]) rxv_cnt[g] <= rxv_cnt[g] + 1;
    end
    if (rxv_x) rxv_x_cnt <= rxv_x_cnt + 1;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rx_sum();
    return rxv_cnt[0] + rxv_cnt[1] + rxv_cnt[2] + rxv_cnt[3];
  endfunction

  int         t_low, t_busy, t_rise, t_rx0;
  logic [3:0] t_seen;
  logic [7:0] t_mosi;
  logic       t_done;

  task automatic xfer(input logic [7:0] d, input logic [1:0] idx, input bit tog, input bit use_x);
    logic       r;
    logic [3:0] s;
    int         rise0;
    @(negedge clk);
    rise0  = rise_cnt;
    t_rx0  = rx_sum();
    data   = d;
    cs_idx = idx;
    if (use_x) valid_x = 1'b1;
    else       valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
    valid_x = 1'b0;
    t_low   = 0;
    t_busy  = 0;
    t_seen  = 4'hF;
    r       = 1'b0;
    for (int i = 0; i < 300; i++) begin
      r = use_x ? ready_x : ready_v[0];
      s = use_x ? {1'b1, sel_x} : sel_flat[3:0];
      if (r) break;
      t_busy++;
      t_seen &= s;
      if (s != 4'hF) t_low++;
      if (tog) begin
        valid  = ~valid;
        data   = 8'hFF;
        cs_idx = 2'd0;
      end
      @(negedge clk);
    end
    valid  = 1'b0;
    t_done = r;
    @(negedge clk);
    @(negedge clk);
    t_rise = rise_cnt - rise0;
    t_mosi = mosi_sh;
  endtask

  task automatic check_rx(input string tag, input logic [7:0] d);
    check({tag, "_rx_data"}, rx_flat, RX_ON ? {4{d}} : 32'h0);
    check({tag, "_rx_pulses"}, 32'(rx_sum() - t_rx0), RX_ON ? 32'd4 : 32'd0);
    check({tag, "_sclk_idle"}, 32'(sclk_v), 32'h0000_000C);
  endtask

  int         c2, c3, bad, gap, acc, rxs;
  logic       seen_hi;
  logic [3:0] s3;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_v), 32'hF);
    check("rst_busy",  32'(busy_v), 32'h0);
    check("rst_sclk",  32'(sclk_v), 32'hC);
    check("rst_mosi",  32'(mosi_v), 32'h0);
    check("rst_sel",   32'(sel_flat), 32'hFFFF);
    check("rst_rx",    rx_flat, 32'h0);
    check("rst_rxv",   32'(rxv_v), 32'h0);
    check("rst_sel_x", 32'(sel_x), 32'h7);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0 A5 to cs 0
    xfer(8'hA5, 2'd0, 1'b0, 1'b0);
    check("t1_done", 32'(t_done), 32'h1);
    check("t1_cs_low_cycles", 32'(t_low), 32'd72);
    check("t1_busy_cycles", 32'(t_busy), 32'd72);
    check("t1_sel_seen", 32'(t_seen), 32'hE);
    check("t1_rises", 32'(t_rise), 32'd8);
    check("t1_mosi", 32'(t_mosi), 32'hA5);
    check_rx("t1", 8'hA5);

    // All modes, loopback 3C
    xfer(8'h3C, 2'd1, 1'b0, 1'b0);
    check("t2_sel_seen", 32'(t_seen), 32'hD);
    check("t2_mosi", 32'(t_mosi), 32'h3C);
    check_rx("t2", 8'h3C);

    // Back-to-back with valid held: idx 2 then 3
    @(negedge clk);
    data = 8'h11; cs_idx = 2'd2; valid = 1'b1;
    acc = 0; seen_hi = 1'b0; c2 = 0; c3 = 0; bad = 0; gap = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      s3 = sel_flat[3:0];
      if (s3 == 4'b1011) c2++;
      else if (s3 == 4'b0111) c3++;
      else if (s3 != 4'hF) bad++;
      else if (acc >= 1 && c2 > 0 && c3 == 0) gap++;
      if (acc == 0 && !ready_v[0]) begin
        acc = 1; data = 8'h22; cs_idx = 2'd3;
      end else if (acc == 1 && ready_v[0]) begin
        seen_hi = 1'b1;
      end else if (acc == 1 && seen_hi && !ready_v[0]) begin
        acc = 2; valid = 1'b0;
      end else if (acc == 2 && ready_v[0]) begin
        break;
      end
    end
    valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_both_accepted", 32'(acc), 32'd2);
    check("t3_cs2_cycles", 32'(c2), 32'd72);
    check("t3_cs3_cycles", 32'(c3), 32'd72);
    check("t3_bad_sel", 32'(bad), 32'd0);
    check("t3_gap_ge1", 32'(gap >= 1), 32'h1);
    check("t3_mosi", 32'(mosi_sh), 32'h22);
    check("t3_ready", 32'(ready_v), 32'hF);

    // valid toggled while busy is ignored
    xfer(8'hC3, 2'd1, 1'b1, 1'b0);
    check("t4_busy_cycles", 32'(t_busy), 32'd72);
    check("t4_sel_seen", 32'(t_seen), 32'hD);
    check("t4_mosi", 32'(t_mosi), 32'hC3);
    check_rx("t4", 8'hC3);
    check("t4_no_extra_accept", 32'(ready_v), 32'hF);
    check("t4_sel_idle", 32'(sel_flat), 32'hFFFF);

    // Reset during SHIFT, bit 4
    @(negedge clk);
    data = 8'h96; cs_idx = 2'd0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    rxs = rx_sum();
    repeat (37) @(negedge clk);
    check("t5_in_shift", 32'(busy_v), 32'hF);
    rst_n = 1'b0;
    #1;
    check("t5_sel", 32'(sel_flat), 32'hFFFF);
    check("t5_sclk", 32'(sclk_v), 32'hC);
    check("t5_ready", 32'(ready_v), 32'hF);
    check("t5_busy", 32'(busy_v), 32'h0);
    check("t5_mosi", 32'(mosi_v), 32'h0);
    check("t5_rx", rx_flat, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_rx_pulse", 32'(rx_sum() - rxs), 32'd0);
    xfer(8'h5A, 2'd0, 1'b0, 1'b0);
    check("t5_next_cs_low", 32'(t_low), 32'd72);
    check("t5_next_rises", 32'(t_rise), 32'd8);
    check("t5_next_mosi", 32'(t_mosi), 32'h5A);
    check_rx("t5_next", 8'h5A);

    // Out-of-range select index
    xfer(8'h77, 2'd3, 1'b0, 1'b1);
    check("t6_done", 32'(t_done), 32'h1);
    check("t6_sel_seen", 32'(t_seen), 32'hF);
    check("t6_busy_cycles", 32'(t_busy), 32'd72);
    check("t6_busy_x", 32'(busy_x), 32'h0);
    check("t6_sclk_x", 32'(sclk_x), 32'h0);
    check("t6_rx_x", 32'(rx_x), RX_ON ? 32'h77 : 32'h0);
    check("t6_rx_pulses_x", 32'(rxv_x_cnt), RX_ON ? 32'd1 : 32'd0);
    check("t6_main_idle", 32'(ready_v), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
